// File: rtl/tetris_pkg.sv
// Shared definitions for the piece-fall controller: state encoding,
// default timing constants and the gravity interval rule.
package tetris_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FALL,
        ST_REQ,
        ST_LAND,
        ST_LOCK
    } fall_state_t;

    localparam int unsigned DROP_TICKS_MAX_DEF = 4;
    localparam int unsigned SOFT_PERIOD_DEF    = 5_000_000;
    localparam int unsigned LOCK_TICKS_DEF     = 2;
    localparam int unsigned TICK_CNT_W         = 4;

    // Higher levels shorten the interval, but never below one tick.
    function automatic logic [4:0] gravity_interval(input logic [3:0] level,
                                                    input logic [4:0] max_ticks);
        logic [4:0] lvl;
        lvl = {1'b0, level};
        if (lvl > max_ticks - 5'd1)
            lvl = max_ticks - 5'd1;
        return max_ticks - lvl;
    endfunction

endpackage

// File: rtl/soft_drop_timer.sv
// Free-running cycle counter for accelerated fall; emits a one-cycle
// expire pulse every PERIOD enabled cycles and holds while disabled.
module soft_drop_timer
    import tetris_pkg::*;
#(
    parameter int unsigned PERIOD = SOFT_PERIOD_DEF
) (
    input  logic clk_in,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    localparam int unsigned W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [W-1:0] LAST = W'(PERIOD - 1);

    logic [W-1:0] cnt_q;

    assign expire = enable && !clear && (cnt_q == LAST);

    always_ff @(posedge clk_in) begin
        if (rst || clear)
            cnt_q <= '0;
        else if (enable)
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    end

endmodule

// File: rtl/fall_controller.sv
// Gravity / soft-drop / hard-drop sequencer for the falling piece, handing
// one-row move requests to the game logic and requesting the final lock.
//
// state | meaning
// IDLE  | no piece in play, all outputs low
// FALL  | piece falling, counting gravity ticks / soft-drop cycles
// REQ   | down_req held until the game acknowledges
// LAND  | piece blocked, waiting LOCK_TICKS before the last move attempt
// LOCK  | one-cycle lock_req, then back to IDLE
module fall_controller
    import tetris_pkg::*;
#(
    parameter int unsigned DROP_TICKS_MAX = DROP_TICKS_MAX_DEF,
    parameter int unsigned SOFT_PERIOD    = SOFT_PERIOD_DEF,
    parameter int unsigned LOCK_TICKS     = LOCK_TICKS_DEF
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       pause,
    input  logic       tick,
    input  logic [3:0] level,
    input  logic       spawn,
    input  logic       soft_drop,
    input  logic       hard_drop,
    input  logic       down_ack,
    input  logic       down_ok,
    output logic       down_req,
    output logic       lock_req,
    output logic       active
);

    localparam logic [4:0] DROP_MAX5 = 5'(DROP_TICKS_MAX);
    localparam logic [4:0] LOCK5     = 5'(LOCK_TICKS);

    fall_state_t               state_q, state_d;
    logic [TICK_CNT_W-1:0]     tick_cnt_q, tick_cnt_d, tick_inc;
    logic                      hard_q, hard_d;
    logic                      land_try_q, land_try_d;
    logic [4:0]                interval;
    logic                      soft_en, soft_clr, soft_expire;

    assign soft_en  = !pause && (state_q == ST_FALL) && soft_drop;
    assign soft_clr = !pause && (spawn || !soft_drop);

    soft_drop_timer #(
        .PERIOD (SOFT_PERIOD)
    ) u_soft_timer (
        .clk_in (clk_in),
        .rst    (rst),
        .enable (soft_en),
        .clear  (soft_clr),
        .expire (soft_expire)
    );

    // Pause freezes every register by simply withholding the update.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            hard_q     <= 1'b0;
            land_try_q <= 1'b0;
        end else if (!pause) begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            hard_q     <= hard_d;
            land_try_q <= land_try_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        hard_d     = hard_q;
        land_try_d = land_try_q;
        tick_inc   = (tick_cnt_q == '1) ? tick_cnt_q : tick_cnt_q + 4'd1;
        interval   = gravity_interval(level, DROP_MAX5);

        if (spawn) begin
            state_d    = ST_FALL;
            tick_cnt_d = '0;
            hard_d     = 1'b0;
            land_try_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_FALL: begin
                    if (hard_drop) begin
                        hard_d     = 1'b1;
                        state_d    = ST_REQ;
                        tick_cnt_d = '0;
                    end else if (soft_expire) begin
                        state_d = ST_REQ;
                        if (tick)
                            tick_cnt_d = tick_inc;
                    end else if (tick) begin
                        if ({1'b0, tick_inc} >= interval) begin
                            state_d    = ST_REQ;
                            tick_cnt_d = '0;
                        end else begin
                            tick_cnt_d = tick_inc;
                        end
                    end
                end
                ST_REQ: begin
                    if (hard_drop)
                        hard_d = 1'b1;
                    // A hard drop keeps requesting until the piece is blocked.
                    if (down_ack) begin
                        if (down_ok) begin
                            if (!(hard_drop || hard_q)) begin
                                state_d    = ST_FALL;
                                land_try_d = 1'b0;
                            end
                        end else if (hard_drop || hard_q || land_try_q) begin
                            state_d = ST_LOCK;
                        end else begin
                            state_d    = ST_LAND;
                            tick_cnt_d = '0;
                        end
                    end
                end
                ST_LAND: begin
                    if (hard_drop) begin
                        hard_d  = 1'b1;
                        state_d = ST_REQ;
                    end else if (tick) begin
                        if ({1'b0, tick_inc} >= LOCK5) begin
                            state_d    = ST_REQ;
                            land_try_d = 1'b1;
                            tick_cnt_d = '0;
                        end else begin
                            tick_cnt_d = tick_inc;
                        end
                    end
                end
                ST_LOCK: begin
                    state_d    = ST_IDLE;
                    tick_cnt_d = '0;
                    hard_d     = 1'b0;
                    land_try_d = 1'b0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign down_req = (state_q == ST_REQ);
    assign lock_req = (state_q == ST_LOCK) && !pause;
    assign active   = (state_q != ST_IDLE);

endmodule

// File: doc/fall_controller.md
FALL_CONTROLLER -- requirements
Module: fall_controller

Interface
REQ-001 Parameter DROP_TICKS_MAX, default 4, meaning tick count per gravity step at level 0.
REQ-002 Parameter SOFT_PERIOD, default 5_000_000, meaning clk_in cycles per step while soft_drop is held.
REQ-003 Parameter LOCK_TICKS, default 2, meaning ticks a landed piece waits before the final lock attempt.
REQ-004 clk_in  input  1  system clock; the only clock in the block.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 pause  input  1  freeze all state, counters and outputs while high.
REQ-007 tick  input  1  gravity tick from the clock block, one clk_in cycle wide.
REQ-008 level  input  4  speed level; values above DROP_TICKS_MAX-1 saturate.
REQ-009 spawn  input  1  one-cycle pulse: a new piece is on the board.
REQ-010 soft_drop  input  1  debounced level: accelerated fall requested.
REQ-011 hard_drop  input  1  one-cycle pulse: drop piece to floor and lock.
REQ-012 down_ack  input  1  game logic has processed down_req this cycle.
REQ-013 down_ok  input  1  qualifies down_ack: 1 = piece moved, 0 = blocked.
REQ-014 down_req  output  1  request a one-row move down; held until down_ack.
REQ-015 lock_req  output  1  one-cycle pulse: freeze piece into board.
REQ-016 active  output  1  high from spawn until lock_req.

Function
REQ-017 States: IDLE, FALL, REQ, LAND, LOCK; in IDLE, down_req, lock_req and active are low.
REQ-018 spawn in any state SHALL enter FALL next cycle, clear all counters and drop any pending down_req.
REQ-019 Gravity interval SHALL be DROP_TICKS_MAX - min(level, DROP_TICKS_MAX-1) ticks; level is sampled on each tick.
REQ-020 In FALL, when the tick counter reaches the interval, the block SHALL enter REQ and clear the tick counter.
REQ-021 In FALL with soft_drop high, a cycle counter SHALL enter REQ every SOFT_PERIOD cycles, and gravity ticks SHALL still count.
REQ-022 In REQ, down_req SHALL be high every cycle until down_ack; at most one outstanding request.
REQ-023 down_ack with down_ok=1 SHALL return to FALL; with down_ok=0, the next state SHALL be LAND.
REQ-024 In LAND, ticks SHALL count to LOCK_TICKS and then issue one down_req; ok returns to FALL, blocked enters LOCK.
REQ-025 LOCK SHALL assert lock_req for exactly one cycle, then enter IDLE.
REQ-026 hard_drop in FALL or LAND SHALL set a hard flag; REQ then repeats back-to-back until blocked, and the block then enters LOCK with no LAND wait.
REQ-027 hard_drop in IDLE, REQ or LOCK SHALL be ignored, except in REQ, where it sets the hard flag.
REQ-028 Same-cycle priority SHALL be rst > pause > spawn > hard_drop > down_ack > soft timer > tick.
REQ-029 While pause is high, tick, spawn, hard_drop and down_ack SHALL be ignored and down_req held; lock_req SHALL be low.
REQ-030 Counters SHALL saturate, never wrap; the tick counter is 4 bits and the soft counter is ceil(log2(SOFT_PERIOD)) bits.

Reset
REQ-031 rst SHALL take priority over pause, force IDLE, clear all counters and the hard flag, and drive down_req=0, lock_req=0, active=0 on the next edge.
REQ-032 rst during REQ SHALL drop down_req without waiting for down_ack.

Structure
REQ-033 State encoding and default parameter constants SHALL live in shared package tetris_pkg.
REQ-034 The SOFT_PERIOD cycle counter SHALL be the sub-module soft_drop_timer, with enable, clear and a one-cycle expire pulse.

Verification
REQ-035 level=1, spawn, then 3 ticks -> down_req rises the cycle after the 3rd tick; ack/ok=1 -> down_req falls and the state returns to FALL.
REQ-036 Blocked ack, then 2 ticks -> one down_req; blocked again -> lock_req pulses 1 cycle, active=0, state IDLE.
REQ-037 hard_drop, then game acks ok 5 times and then blocked -> exactly 6 down_req handshakes, lock_req with no tick needed.
REQ-038 SOFT_PERIOD=10, soft_drop held, acks ok -> down_req issued every 10 cycles (+ ack latency), no ticks applied.
REQ-039 pause high for 50 cycles with ticks during REQ -> down_req stays high, counters unchanged; after release, behaviour resumes.
REQ-040 rst asserted during REQ together with pause -> next edge all outputs 0, IDLE; a later spawn restarts cleanly.
